// File: rtl/wino_tile_sched.sv
// Row scheduler for the F(6,3) Winograd core: cuts a sample stream into overlapping 8-sample tiles,
// tracks core latency, and buffers results under credit. Optional stats ports: WINO_SCHED_STATS_EN.
module wino_tile_sched #(
  parameter int DW          = 10,
  parameter int ZW          = 10,
  parameter int LAT         = 6,
  parameter int ROW_LEN     = 38,
  parameter int OFIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            s_valid,
  input  logic [DW-1:0]   s_data,
  output logic            s_ready,
  output logic [8*DW-1:0] wc_d,
  input  logic [6*ZW-1:0] wc_z,
  output logic            m_valid,
  output logic [6*ZW-1:0] m_data,
  input  logic            m_ready,
  output logic            m_last,
  output logic            busy,
  output logic            done
`ifdef WINO_SCHED_STATS_EN
  ,
  output logic [15:0]     stall_cnt,
  output logic [15:0]     tile_total
`endif
);

  localparam int TILES = (ROW_LEN - 2) / 6;
  localparam int TW    = (TILES > 1) ? $clog2(TILES) : 1;
  localparam int PW    = $clog2(OFIFO_DEPTH);
  localparam int FCW   = $clog2(OFIFO_DEPTH + 1);
  localparam int CW    = $clog2(OFIFO_DEPTH + LAT + 2) + 1;

  typedef enum logic [2:0] {IDLE, FILL, ISSUE, STEP, DRAIN} state_t;

  state_t          state;
  logic [DW-1:0]   w [8];
  logic [2:0]      sidx;
  logic [TW-1:0]   tile_cnt;
  logic            pres, pres_last;
  logic [LAT-1:0]  sr, lsr;
  logic [6*ZW-1:0] mem [OFIFO_DEPTH];
  logic            lmem [OFIFO_DEPTH];
  logic [PW-1:0]   rd, wr;
  logic [FCW-1:0]  fcount;
  logic [CW-1:0]   inflight;
  logic            credit, last_tile, push, pop;

  // wc_d is registered, so the tile is on the core's input one cycle after the issue decision;
  // pres covers that cycle so sr[LAT-1] lines up with the matching Z.
  always_comb begin
    inflight = CW'(pres);
    for (int unsigned i = 0; i < LAT; i++) inflight = inflight + CW'(sr[i]);
  end

  assign credit    = (CW'(fcount) + inflight) < CW'(OFIFO_DEPTH);
  assign last_tile = (tile_cnt == TW'(TILES - 1));
  assign push      = sr[LAT-1];
  assign pop       = m_valid && m_ready;
  assign m_valid   = (fcount != '0);
  assign m_data    = mem[rd];
  assign m_last    = lmem[rd];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      s_ready   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wc_d      <= '0;
      sidx      <= '0;
      tile_cnt  <= '0;
      pres      <= 1'b0;
      pres_last <= 1'b0;
      sr        <= '0;
      lsr       <= '0;
    end else begin
      done <= 1'b0;
      pres <= 1'b0;
      sr   <= {sr[LAT-2:0], pres};
      lsr  <= {lsr[LAT-2:0], pres_last};
      case (state)
        IDLE: if (start) begin
          state   <= FILL;
          busy    <= 1'b1;
          s_ready <= 1'b1;
          sidx    <= '0;
        end
        FILL, STEP: if (s_valid && s_ready) begin
          w[sidx] <= s_data;
          if (sidx == 3'd7) begin
            s_ready <= 1'b0;
            sidx    <= '0;
            state   <= ISSUE;
          end else begin
            sidx <= sidx + 1'b1;
          end
        end
        ISSUE: if (credit) begin
          wc_d      <= {w[0], w[1], w[2], w[3], w[4], w[5], w[6], w[7]};
          pres      <= 1'b1;
          pres_last <= last_tile;
          if (last_tile) begin
            tile_cnt <= '0;
            state    <= DRAIN;
          end else begin
            tile_cnt <= tile_cnt + 1'b1;
            w[0]     <= w[6];
            w[1]     <= w[7];
            sidx     <= 3'd2;
            s_ready  <= 1'b1;
            state    <= STEP;
          end
        end
        DRAIN: if (inflight == '0 && fcount == '0) begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr]  <= wc_z;
      lmem[wr] <= lsr[LAT-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd     <= '0;
      wr     <= '0;
      fcount <= '0;
    end else begin
      if (push) wr <= (wr == PW'(OFIFO_DEPTH - 1)) ? '0 : wr + 1'b1;
      if (pop)  rd <= (rd == PW'(OFIFO_DEPTH - 1)) ? '0 : rd + 1'b1;
      case ({push, pop})
        2'b10:   fcount <= fcount + 1'b1;
        2'b01:   fcount <= fcount - 1'b1;
        default: fcount <= fcount;
      endcase
    end
  end

`ifdef WINO_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= '0;
      tile_total <= '0;
    end else if (state == ISSUE) begin
      if (!credit && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (credit && tile_total != '1) tile_total <= tile_total + 1'b1;
    end
  end
`endif

endmodule
